// File: rtl/reg_write_arbiter.sv
// Round-robin arbiter for the register unit's single write port, with registered one-hot enables.
// Define REG_ARB_INIT_EN to compile in the post-reset sweep that zeroes registers 1..2**ADDR_W-1.
module reg_write_arbiter #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 5
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     req0_valid,
  input  logic [ADDR_W-1:0]        req0_addr,
  input  logic [DATA_W-1:0]        req0_data,
  output logic                     req0_ready,
  input  logic                     req1_valid,
  input  logic [ADDR_W-1:0]        req1_addr,
  input  logic [DATA_W-1:0]        req1_data,
  output logic                     req1_ready,
  output logic                     wr_en,
  output logic [ADDR_W-1:0]        wr_addr,
  output logic [DATA_W-1:0]        wr_data,
  output logic [(2**ADDR_W)-1:0]   reg_en,
  output logic                     busy
);

  localparam int NREG = 2**ADDR_W;

  typedef enum logic {ST_INIT, ST_RUN} state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic                r_last_grant;
  logic                w_sweep_we;
  logic [ADDR_W-1:0]   w_sweep_addr;

  logic                w_run;
  logic                w_gnt0;
  logic                w_gnt1;
  logic                w_xfer;
  logic [ADDR_W-1:0]   w_sel_addr;
  logic [DATA_W-1:0]   w_sel_data;

  logic                w_wr_en_nxt;
  logic [ADDR_W-1:0]   w_wr_addr_nxt;
  logic [DATA_W-1:0]   w_wr_data_nxt;
  logic [NREG-1:0]     w_reg_en_nxt;

  logic                r_wr_en;
  logic [ADDR_W-1:0]   r_wr_addr;
  logic [DATA_W-1:0]   r_wr_data;
  logic [NREG-1:0]     r_reg_en;

`ifdef REG_ARB_INIT_EN
  logic [ADDR_W-1:0]   r_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= ST_INIT;
      r_cnt   <= ADDR_W'(1);
    end else begin
      r_state <= w_state_nxt;
      if (r_state == ST_INIT) r_cnt <= r_cnt + 1'b1;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_sweep_we   = 1'b0;
    w_sweep_addr = r_cnt;
    if (r_state == ST_INIT) begin
      w_sweep_we = 1'b1;
      if (r_cnt == '1) w_state_nxt = ST_RUN;
    end
  end
`else
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_RUN;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt  = ST_RUN;
    w_sweep_we   = 1'b0;
    w_sweep_addr = '0;
  end
`endif

  // r_last_grant = 1 means requester 1 won most recently, so requester 0 wins the next tie.
  always_comb begin
    w_run      = (r_state == ST_RUN);
    w_gnt0     = w_run & req0_valid & (~req1_valid | r_last_grant);
    w_gnt1     = w_run & req1_valid & (~req0_valid | ~r_last_grant);
    w_xfer     = w_gnt0 | w_gnt1;
    w_sel_addr = w_gnt1 ? req1_addr : req0_addr;
    w_sel_data = w_gnt1 ? req1_data : req0_data;
  end

  always_comb begin
    w_wr_en_nxt   = 1'b0;
    w_wr_addr_nxt = r_wr_addr;
    w_wr_data_nxt = r_wr_data;
    if (w_sweep_we) begin
      w_wr_en_nxt   = 1'b1;
      w_wr_addr_nxt = w_sweep_addr;
      w_wr_data_nxt = '0;
    end else if (w_xfer) begin
      w_wr_en_nxt   = (w_sel_addr != '0);
      w_wr_addr_nxt = w_sel_addr;
      w_wr_data_nxt = w_sel_data;
    end
  end

  always_comb begin
    w_reg_en_nxt = '0;
    for (int unsigned i = 1; i < NREG; i++) begin
      w_reg_en_nxt[i] = w_wr_en_nxt && (w_wr_addr_nxt == ADDR_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_last_grant <= 1'b1;
      r_wr_en      <= 1'b0;
      r_wr_addr    <= '0;
      r_wr_data    <= '0;
      r_reg_en     <= '0;
    end else begin
      if (w_gnt0) r_last_grant <= 1'b0;
      if (w_gnt1) r_last_grant <= 1'b1;
      r_wr_en   <= w_wr_en_nxt;
      r_wr_addr <= w_wr_addr_nxt;
      r_wr_data <= w_wr_data_nxt;
      r_reg_en  <= w_reg_en_nxt;
    end
  end

  assign req0_ready = w_gnt0;
  assign req1_ready = w_gnt1;
  assign wr_en      = r_wr_en;
  assign wr_addr    = r_wr_addr;
  assign wr_data    = r_wr_data;
  assign reg_en     = r_reg_en;
  assign busy       = (r_state == ST_INIT);

endmodule

// File: tb/tb_reg_write_arbiter.sv
// Randomized self-checking bench for reg_write_arbiter against a transaction-level model.
// Honours REG_ARB_INIT_EN the same way as the design.
module tb_reg_write_arbiter;

  localparam int DW = 32;
  localparam int AW = 5;
  localparam int NR = 2**AW;
`ifdef REG_ARB_INIT_EN
  localparam bit INIT_ON = 1'b1;
`else
  localparam bit INIT_ON = 1'b0;
`endif

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req0_valid, req1_valid;
  logic [AW-1:0] req0_addr, req1_addr;
  logic [DW-1:0] req0_data, req1_data;
  logic          req0_ready, req1_ready;
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [DW-1:0] wr_data;
  logic [NR-1:0] reg_en;
  logic          busy;

  always #5 clk = ~clk;

  reg_write_arbiter #(.DATA_W(DW), .ADDR_W(AW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .req0_valid (req0_valid),
    .req0_addr  (req0_addr),
    .req0_data  (req0_data),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_addr  (req1_addr),
    .req1_data  (req1_data),
    .req1_ready (req1_ready),
    .wr_en      (wr_en),
    .wr_addr    (wr_addr),
    .wr_data    (wr_data),
    .reg_en     (reg_en),
    .busy       (busy)
  );

  int n_chk  = 0;
  int n_pass = 0;

  // Pending request of each requester, plus the model's memory of who won last.
  bit            v [2];
  logic [AW-1:0] a [2];
  logic [DW-1:0] d [2];
  int            last_g;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
  endtask

  task automatic drive();
    req0_valid = v[0]; req0_addr = a[0]; req0_data = d[0];
    req1_valid = v[1]; req1_addr = a[1]; req1_data = d[1];
  endtask

  task automatic new_req(input int i);
    v[i] = ($urandom_range(0, 9) < 7);
    a[i] = ($urandom_range(0, 7) == 0) ? '0 : AW'($urandom);
    d[i] = $urandom;
  endtask

  // One RUN-mode cycle: check ready against the model's choice, clock, check the write port.
  task automatic step(output int g);
    logic          exp_en;
    logic [NR-1:0] exp_reg;
    if (v[0] && v[1]) g = (last_g == 0) ? 1 : 0;
    else if (v[0])    g = 0;
    else if (v[1])    g = 1;
    else              g = -1;
    check("req0_ready", req0_ready, g == 0);
    check("req1_ready", req1_ready, g == 1);
    @(posedge clk); #1;
    exp_en  = 1'b0;
    exp_reg = '0;
    if (g >= 0) begin
      last_g = g;
      exp_en = (a[g] != 0);
      if (exp_en) exp_reg[a[g]] = 1'b1;
      check("wr_addr", wr_addr, a[g]);
      check("wr_data", wr_data, d[g]);
    end
    check("wr_en", wr_en, exp_en);
    check("reg_en", reg_en, exp_reg);
    check("busy_run", busy, 0);
  endtask

  task automatic run_random(input int n);
    int g;
    for (int k = 0; k < n; k++) begin
      step(g);
      for (int i = 0; i < 2; i++) if (g == i || !v[i]) new_req(i);
      drive(); #1;
    end
  endtask

  task automatic drain();
    int g;
    for (int k = 0; k < 10; k++) begin
      if (!v[0] && !v[1]) break;
      step(g);
      if (g >= 0) v[g] = 0;
      drive(); #1;
    end
    check("drained", {v[0], v[1]}, 2'b00);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    v[0] = 0; v[1] = 0;
    a[0] = '0; a[1] = '0; d[0] = '0; d[1] = '0;
    drive();
    repeat (2) @(posedge clk);
    #1;
    check("rst_wr_en", wr_en, 0);
    check("rst_wr_addr", wr_addr, 0);
    check("rst_wr_data", wr_data, 0);
    check("rst_reg_en", reg_en, 0);
    check("rst_ready0", req0_ready, 0);
    check("rst_ready1", req1_ready, 0);
    check("rst_busy", busy, INIT_ON);
    last_g = 1;
    rst_n  = 1'b1;
    #1;
  endtask

  // Both requesters hold valid during the sweep; neither may be granted until busy drops.
  task automatic sweep_check(input int upto);
    logic [NR-1:0] exp_reg;
    check("sweep_busy0", busy, 1);
    check("sweep_rdy0_pre", req0_ready, 0);
    check("sweep_rdy1_pre", req1_ready, 0);
    for (int k = 1; k <= upto; k++) begin
      @(posedge clk); #1;
      exp_reg = '0;
      exp_reg[k] = 1'b1;
      check("sweep_wr_en", wr_en, 1);
      check("sweep_wr_addr", wr_addr, k);
      check("sweep_wr_data", wr_data, 0);
      check("sweep_reg_en", reg_en, exp_reg);
      check("sweep_busy", busy, k < NR - 1);
      if (k < NR - 1) begin
        check("sweep_rdy0", req0_ready, 0);
        check("sweep_rdy1", req1_ready, 0);
      end
    end
  endtask

  task automatic directed();
    int g;
    drain();
    v[0] = 1; a[0] = 5; d[0] = 32'hDEADBEEF; drive(); #1;
    step(g);
    v[0] = 0; drive(); #1;
    step(g);
    v[0] = 1; a[0] = 3; d[0] = $urandom;
    v[1] = 1; a[1] = 7; d[1] = $urandom;
    drive(); #1;
    for (int k = 0; k < 4; k++) begin
      step(g);
      if (g >= 0) d[g] = $urandom;
      drive(); #1;
    end
    drain();
    v[1] = 1; a[1] = 0; d[1] = 32'h1234; drive(); #1;
    step(g);
    v[1] = 0; drive(); #1;
    v[0] = 1; a[0] = 9; d[0] = 32'hAAAA5555;
    v[1] = 1; a[1] = 9; d[1] = 32'h5555AAAA;
    drive(); #1;
    drain();
  endtask

  initial begin
    int g;
    do_reset();
`ifdef REG_ARB_INIT_EN
    new_req(0); new_req(1); v[0] = 1; v[1] = 1; drive(); #1;
    sweep_check(NR - 1);
    run_random(100);
    directed();
    do_reset();
    v[0] = 1; v[1] = 1; drive(); #1;
    sweep_check(12);
    #2 rst_n = 1'b0;
    #1;
    check("midrst_wr_en", wr_en, 0);
    check("midrst_reg_en", reg_en, 0);
    check("midrst_wr_addr", wr_addr, 0);
    check("midrst_busy", busy, 1);
    do_reset();
    v[0] = 1; v[1] = 1; drive(); #1;
    sweep_check(NR - 1);
`else
    v[0] = 1; a[0] = 5'd31; d[0] = 32'd1; drive(); #1;
    check("nomacro_busy", busy, 0);
    step(g);
    v[0] = 0; drive(); #1;
    directed();
`endif
    run_random(400);
    drain();
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not reach its summary");
    $fatal(1);
  end

endmodule

// File: doc/reg_write_arbiter.md
# reg_write_arbiter

Shares the register unit's single write port between two requesters: the core writeback path (requester 0) and a secondary writer such as a load/debug path (requester 1). It arbitrates round-robin, registers the winning write, and decodes it into a one-hot enable vector that drives the per-register flip-flop `en` inputs. An optional post-reset sweep clears every architectural register before normal traffic is accepted. Register x0 is never written.

## Interface
- `DATA_W`, default 32: register data width.
- `ADDR_W`, default 5: register address width; the register count is 2**ADDR_W.

- `clk`  in  1  rising-edge clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `req0_valid`  in  1  requester 0 has a write pending.
- `req0_addr`  in  ADDR_W  requester 0 destination register.
- `req0_data`  in  DATA_W  requester 0 write data.
- `req0_ready`  out  1  requester 0 write accepted this cycle.
- `req1_valid` / `req1_addr` / `req1_data` / `req1_ready`: same as above, for requester 1.
- `wr_en`  out  1  registered write strobe to the register unit.
- `wr_addr`  out  ADDR_W  registered write address.
- `wr_data`  out  DATA_W  registered write data.
- `reg_en`  out  2**ADDR_W  one-hot per-register enable; bit i = `wr_en` & (`wr_addr` == i); bit 0 is always 0.
- `busy`  out  1  high while the init sweep runs.

## Operation
- FSM states: INIT, RUN.
- Reset state:
  - INIT when `REG_ARB_INIT_EN` is defined, otherwise RUN.
  - Sweep counter = 1; `last_grant` = 1, so requester 0 wins the first tie.
- INIT:
  - Each cycle, drive a write of data 0 to address = counter, then increment the counter.
  - After address 2**ADDR_W−1 is written, go to RUN.
  - Both `req*_ready` are held 0; `busy` = 1.
- RUN, `busy` = 0:
  - Only requester 0 valid: `req0_ready` = 1. Only requester 1 valid: `req1_ready` = 1.
  - Both valid: grant the requester ≠ `last_grant`.
  - `last_grant` updates only on a grant.
  - `ready` is combinational from `valid` and `last_grant`; exactly zero or one `ready` is high per cycle.
- Handshake:
  - A transfer occurs on a rising edge where `valid` & `ready` are both high.
  - The requester holds `valid`, `addr` and `data` stable until its transfer.
  - A losing requester waits; under continuous contention it is granted on the next cycle.
- x0 writes:
  - A request to address 0 is accepted (`ready` high, `last_grant` updates).
  - `wr_en` stays 0 for that slot and `reg_en` stays all-zero.
- Same-address writes from both requesters are serialized; the later grant's data persists.

## Timing
- Reset values: `wr_en` = 0, `wr_addr` = 0, `wr_data` = 0, `reg_en` = 0, both `ready` = 0.
- `busy` at reset: 1 if `REG_ARB_INIT_EN` is defined, else 0.
- Latency:
  - Request accepted at edge N → `wr_en`/`wr_addr`/`wr_data`/`reg_en` valid during cycle N→N+1.
  - The register unit captures the write at edge N+1.
- Throughput: one write per cycle. `wr_en` deasserts in the cycle after an edge with no transfer.
- INIT timing:
  - Sweep writes appear on `wr_*` for 2**ADDR_W−1 consecutive cycles (31 with defaults) after `rst_n` rises.
  - `busy` falls the cycle after the last sweep write is issued.
  - `ready` can first assert in that same cycle.
- Reset mid-operation: asynchronous return to the reset state with all outputs cleared immediately. An in-flight write is dropped, and the sweep restarts from address 1.

## Configuration
- `REG_ARB_INIT_EN` defined: INIT state and sweep counter are compiled in; every register 1..2**ADDR_W−1 is zeroed after reset.
- `REG_ARB_INIT_EN` not defined: no INIT logic; the block resets directly into RUN with `busy` tied 0 and accepts requests in the first cycle after `rst_n` rises.

## Test plan
- Init sweep (macro on): release `rst_n` → `wr_en` = 1 with `wr_addr` 1,2,…,31 and `wr_data` 0 on 31 consecutive cycles; `reg_en` = 1<<addr each cycle; `busy` falls afterwards; no `ready` during the sweep.
- Single write: `req0` addr 5, data 0xDEADBEEF held valid → `req0_ready` high 1 cycle; next cycle `wr_en` = 1, `wr_addr` = 5, `wr_data` = 0xDEADBEEF, `reg_en` = 0x00000020.
- Contention: both valid continuously with addr 3 and 7 respectively, each requester presenting a new request after its grant → grants alternate 0,1,0,1 starting with requester 0; `wr_addr` sequence 3,7,3,7.
- x0 write: `req1` addr 0, data 0x1234 → `req1_ready` = 1, `wr_en` = 0, `reg_en` = 0.
- Reset mid-sweep: drop `rst_n` while `wr_addr` = 12 → `wr_en` = 0 immediately; after release the sweep restarts at address 1.
- Macro off: `req0` addr 31, data 1 valid in the first cycle after reset → `req0_ready` = 1 immediately; `busy` is never 1.
